synchronous_fifo: RTL and testbench
===================================

// Module: synchronous_fifo
// PURPOSE
//   Single-clock first-in/first-out buffer with registered read data and
//   full/empty status. Decouples a producer and a consumer running in the
//   same clock domain. Storage is an internal register array; no CDC logic.
// PARAMETERS
//   DATA_WIDTH  8   width of each stored word (>=1)
//   DEPTH       16  number of entries; power of two, >=2; ADDR_W = $clog2(DEPTH)
// PORTS
//   clk         in   1             system clock; all state updates on rising edge
//   rst         in   1             reset, asynchronous, active-low (0 = reset)
//   wr_en       in   1             write request; din captured when accepted
//   rd_en       in   1             read request; head word moved to dout when accepted
//   din         in   DATA_WIDTH    write data
//   dout        out  DATA_WIDTH    registered read data
//   full        out  1             DEPTH entries held
//   empty       out  1             zero entries held
//   count       out  ADDR_W+1      current occupancy, 0..DEPTH
//   overflow    out  1             1-cycle pulse: write rejected because full
//   underflow   out  1             1-cycle pulse: read rejected because empty
// BEHAVIOUR
//   - Single clock, asynchronous active-low reset on rst. While rst=0:
//     wr_ptr=rd_ptr=0, count=0, dout=0, empty=1, full=0, overflow=underflow=0.
//     Memory contents are not reset. Reset mid-operation discards all data.
//   - Pointers are ADDR_W+1 bits; the extra MSB distinguishes full from empty.
//     empty = (wr_ptr==rd_ptr); full = addr bits equal and MSBs differ.
//     Pointers wrap naturally modulo 2*DEPTH; addresses wrap at DEPTH-1 -> 0.
//   - Write accepted when wr_en=1 and (!full or read accepted same edge):
//     mem[wr_ptr[ADDR_W-1:0]] <= din, wr_ptr++.
//   - Read accepted when rd_en=1 and !empty: dout <= mem[rd_ptr addr], rd_ptr++.
//     Latency: data appears on dout one clock after the accepting edge.
//     dout holds its last value when no read is accepted.
//   - Simultaneous wr_en & rd_en:
//     * neither full nor empty: both proceed, count unchanged;
//     * full: both proceed (read frees the slot), full stays 1;
//     * empty: only the write proceeds; no read-through; underflow pulses.
//   - Rejected write (full, no accepted read): ptr/mem unchanged, overflow=1
//     for that cycle. Rejected read (empty): dout unchanged, underflow=1.
//   - count = wr_ptr - rd_ptr (ADDR_W+1-bit modular subtraction).
//   - full/empty/count are registered-state derived (combinational from
//     pointers); they update in the cycle after the edge that changed them.
// TESTING
//   1 Reset: hold rst=0 -> empty=1, full=0, count=0, dout=0; release rst=1.
//   2 Fill: write 1..16 on consecutive edges -> after 16th edge full=1,
//     count=16, empty=0; a 17th write (din=17) is dropped, overflow pulses.
//   3 Drain: 16 reads -> dout sequence 1,2,...,16 one cycle after each read;
//     then empty=1, count=0; extra read pulses underflow, dout stays 16.
//   4 Mixed: write 8'hAA, 8'hBB, then read -> dout=8'hAA next cycle, count=1;
//     second read -> dout=8'hBB, empty=1.
//   5 Simultaneous: at full, wr_en=rd_en=1 with din=8'h55 -> full stays 1,
//     oldest word on dout, 8'h55 later read last; at empty, both asserted ->
//     only write occurs, count=1.
//   6 Wrap/reset: run 40 write/read pairs (pointer wrap) checking order; then
//     assert rst=0 mid-stream -> empty=1, count=0 immediately (async).

Source files
------------

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with registered read data, full/empty/count status and
// one-cycle overflow/underflow indications for rejected requests.
module synchronous_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Pointers carry one extra MSB so a full buffer is distinguishable from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign count = wr_ptr - rd_ptr;

    // A read on the same edge frees the slot, so a full buffer still takes a write.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    assign overflow  = rst && wr_en && !wr_accept;
    assign underflow = rst && rd_en && empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed bench for synchronous_fifo: a queue model tracks contents and
// predicts dout, status flags and rejected-request pulses every cycle.
module tb_synchronous_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = $clog2(DEPTH);

    logic                  clk;
    logic                  rst;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;

    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] exp_dout;
    int checks;
    int errors;

    synchronous_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_status();
        check("dout", 32'(dout), 32'(exp_dout));
        check("count", 32'(count), 32'(exp_q.size()));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
    endtask

    // Entered just after a rising edge; drives one request cycle and checks it.
    task automatic cycle(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
        bit rd_ok;
        bit wr_ok;
        wr_en = w;
        rd_en = r;
        din   = d;
        rd_ok = r && (exp_q.size() > 0);
        wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
        @(negedge clk);
        check("overflow", 32'(overflow), 32'(w && !wr_ok));
        check("underflow", 32'(underflow), 32'(r && !rd_ok));
        @(posedge clk);
        if (rd_ok) exp_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_status();
    endtask

    task automatic apply_reset();
        rst   = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'hFF;
        exp_q.delete();
        exp_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check_status();
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] d;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        exp_dout = '0;
        @(posedge clk);
        #1;

        // reset state
        apply_reset();

        // fill to full, then a dropped 17th write
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 8'd17);

        // drain in order, then a rejected read leaves dout at 16
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        check("dout_hold", 32'(dout), 32'd16);

        // mixed writes and reads
        cycle(1'b1, 1'b0, 8'hAA);
        cycle(1'b1, 1'b0, 8'hBB);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);

        // simultaneous access while full, then while empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        cycle(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        check("last_is_55", 32'(dout), 32'h55);
        cycle(1'b1, 1'b1, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);

        // long run across pointer wrap, mixing random request patterns
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            cycle(1'b1, 1'b0, d);
            cycle(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        // asynchronous reset between edges with data held
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_dout = '0;
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
